vc_out_sched: RTL and testbench

- Per-output-port scheduler for a router.
- Shares one output link among NUM_VC virtual-channel flit buffers and selects the VC allowed to send each cycle.
- Uses wormhole locking: once a multi-flit packet starts on a VC, only that VC is served until its tail flit is sent.
- Tracks downstream buffer space with per-VC credit counters. The output link is a registered valid/ready stage tagged with the VC id.

---
 rtl/vc_sched_pkg.sv | 21 ++
 rtl/vc_sched_arbiter.sv | 29 ++
 rtl/vc_out_sched.sv | 157 +++++++++++++++
 tb/tb_vc_out_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vc_sched_pkg.sv
// Shared types for the VC schedulers: flit header layout, flit types and credit default.
package vc_sched_pkg;

    localparam int TYPE_W      = 2;
    localparam int SIZE_W      = 8;
    localparam int HDR_W       = TYPE_W + SIZE_W;
    localparam int DEF_CREDITS = 2;

    typedef enum logic [TYPE_W-1:0] {
        FLIT_HEAD = 2'b00,
        FLIT_BODY = 2'b01,
        FLIT_TAIL = 2'b10
    } e_flit_type_t;

    // Top HDR_W bits of every flit: type, then packet size.
    typedef struct packed {
        e_flit_type_t      ftype;
        logic [SIZE_W-1:0] pkt_size;
    } s_vc_sched_flit_t;

endpackage

// File: rtl/vc_sched_arbiter.sv
// One-hot request picker: fixed highest-index priority, or round-robin from i_ptr when RR_EN is set.
module vc_sched_arbiter #(
    parameter int N     = 3,
    parameter bit RR_EN = 1'b0,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Fixed mode walks downward from N-1; round-robin walks upward from the pointer with wrap.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = 0; off < N; off++) begin
            w_idx = RR_EN ? PTR_W'((int'(i_ptr) + off) % N) : PTR_W'(N - 1 - off);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_out_sched.sv
// Output-port VC scheduler with wormhole locking and per-VC credit counters.
// Build option: define VC_SCHED_RR_EN for round-robin selection among heads.
//
// state     | meaning
// ST_IDLE   | no packet in flight; any HEAD with credit may win
// ST_LOCKED | multi-flit packet on r_lock_vc; only that VC is served until its TAIL
module vc_out_sched
    import vc_sched_pkg::*;
#(
    parameter int NUM_VC     = 3,
    parameter int FLIT_WIDTH = 34,
    parameter int CREDITS    = DEF_CREDITS,
    localparam int VC_W      = $clog2(NUM_VC),
    localparam int CNT_W     = $clog2(CREDITS + 1)
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic [NUM_VC*FLIT_WIDTH-1:0] fdata_i,
    input  logic [NUM_VC-1:0]            valid_i,
    output logic [NUM_VC-1:0]            ready_o,
    output logic [FLIT_WIDTH-1:0]        fdata_o,
    output logic [VC_W-1:0]              vc_id_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    input  logic [NUM_VC-1:0]            credit_i,
    output logic                         credit_err_o
);

    typedef enum logic {ST_IDLE, ST_LOCKED} e_state_t;

    e_state_t          r_state, w_state_nxt;
    logic [VC_W-1:0]   r_lock_vc, w_lock_nxt;
    logic [CNT_W-1:0]  r_cnt [NUM_VC];
    logic              r_valid;
    logic [FLIT_WIDTH-1:0] r_fdata;
    logic [VC_W-1:0]   r_vc_id;
    logic              r_err;

    logic              w_load_ok;
    s_vc_sched_flit_t  w_hd [NUM_VC];
    logic [NUM_VC-1:0] w_req, w_gnt;
    logic              w_any;
    logic [VC_W-1:0]   w_g;
    logic [VC_W-1:0]   w_ptr;
    logic [FLIT_WIDTH-1:0] w_gflit;
    s_vc_sched_flit_t  w_ghd;

`ifdef VC_SCHED_RR_EN
    localparam bit RR_EN = 1'b1;
    logic [VC_W-1:0] r_ptr;

    // Pointer only advances on grants taken while unlocked, i.e. packet heads.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_ptr <= '0;
        else if (r_state == ST_IDLE && w_any)
            r_ptr <= (w_g == VC_W'(NUM_VC - 1)) ? '0 : w_g + 1'b1;
    end
    assign w_ptr = r_ptr;
`else
    localparam bit RR_EN = 1'b0;
    assign w_ptr = '0;
`endif

    assign w_load_ok = ~r_valid | ready_i;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_req
        assign w_hd[v]  = s_vc_sched_flit_t'(fdata_i[v*FLIT_WIDTH + FLIT_WIDTH - 1 -: HDR_W]);
        assign w_req[v] = valid_i[v] && (r_cnt[v] != '0) && w_load_ok &&
                          ((r_state == ST_IDLE) ? (w_hd[v].ftype == FLIT_HEAD)
                                                : (r_lock_vc == VC_W'(v)));
    end

    vc_sched_arbiter #(.N(NUM_VC), .RR_EN(RR_EN)) u_arb (
        .i_req (w_req),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_g = '0;
        for (int i = 0; i < NUM_VC; i++)
            if (w_gnt[i]) w_g = VC_W'(i);
    end

    assign w_any   = |w_gnt;
    assign w_gflit = fdata_i[int'(w_g)*FLIT_WIDTH +: FLIT_WIDTH];
    assign w_ghd   = w_hd[w_g];
    assign ready_o = arst ? '0 : w_gnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= ST_IDLE;
            r_lock_vc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_vc <= w_lock_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_vc;
        case (r_state)
            ST_IDLE: begin
                if (w_any && w_ghd.ftype == FLIT_HEAD && w_ghd.pkt_size != '0) begin
                    w_state_nxt = ST_LOCKED;
                    w_lock_nxt  = w_g;
                end
            end
            ST_LOCKED: begin
                if (w_any && w_g == r_lock_vc && w_ghd.ftype == FLIT_TAIL)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_valid <= 1'b0;
            r_fdata <= '0;
            r_vc_id <= '0;
        end else if (w_any) begin
            r_valid <= 1'b1;
            r_fdata <= w_gflit;
            r_vc_id <= w_g;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // A grant and a returned credit on the same VC cancel out.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int v = 0; v < NUM_VC; v++) r_cnt[v] <= CNT_W'(CREDITS);
            r_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_gnt[v] && !credit_i[v])
                    r_cnt[v] <= r_cnt[v] - 1'b1;
                else if (credit_i[v] && !w_gnt[v]) begin
                    if (r_cnt[v] == CNT_W'(CREDITS))
                        r_err <= 1'b1;
                    else
                        r_cnt[v] <= r_cnt[v] + 1'b1;
                end
            end
        end
    end

    assign fdata_o      = r_fdata;
    assign vc_id_o      = r_vc_id;
    assign valid_o      = r_valid;
    assign credit_err_o = r_err;

endmodule

// File: tb/tb_vc_out_sched.sv
// Directed bench for vc_out_sched (NUM_VC=3, FLIT_WIDTH=34, CREDITS=2); honours VC_SCHED_RR_EN.
module tb_vc_out_sched;

    localparam int NV = 3;
    localparam int FW = 34;

    logic            clk = 1'b0;
    logic            arst;
    logic [NV*FW-1:0] fdata_i;
    logic [NV-1:0]   valid_i;
    logic [NV-1:0]   ready_o;
    logic [FW-1:0]   fdata_o;
    logic [1:0]      vc_id_o;
    logic            valid_o;
    logic            ready_i;
    logic [NV-1:0]   credit_i;
    logic            credit_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    vc_out_sched #(.NUM_VC(NV), .FLIT_WIDTH(FW), .CREDITS(2)) dut (
        .clk          (clk),
        .arst         (arst),
        .fdata_i      (fdata_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .fdata_o      (fdata_o),
        .vc_id_o      (vc_id_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .credit_i     (credit_i),
        .credit_err_o (credit_err_o)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10;

    typedef struct {
        logic [2:0]    valid;
        logic [FW-1:0] f0, f1, f2;
        logic          rdy;
        logic [2:0]    cr;
        logic [2:0]    exp_rdy;
        logic          exp_v;
        logic [1:0]    exp_vc;
        logic [FW-1:0] exp_d;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic [7:0] sz,
                                         input logic [23:0] p);
        return {t, sz, p};
    endfunction

    task automatic addv(input logic [2:0] valid, input logic [FW-1:0] f0, f1, f2,
                        input logic rdy, input logic [2:0] cr, input logic [2:0] exp_rdy,
                        input logic exp_v, input logic [1:0] exp_vc,
                        input logic [FW-1:0] exp_d, input logic exp_err);
        vec_t r;
        r.valid = valid; r.f0 = f0; r.f1 = f1; r.f2 = f2; r.rdy = rdy; r.cr = cr;
        r.exp_rdy = exp_rdy; r.exp_v = exp_v; r.exp_vc = exp_vc; r.exp_d = exp_d;
        r.exp_err = exp_err;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] valid, input logic [FW-1:0] f0, f1, f2,
                         input logic rdy, input logic [2:0] cr);
        valid_i  = valid;
        fdata_i  = {f2, f1, f0};
        ready_i  = rdy;
        credit_i = cr;
    endtask

    logic [FW-1:0] A0, A2, B0, B1, B2, B3, C2, D0, D1, D2, E0, E1, E2, E3, E4, F0, F1, G2, Z;

    initial begin
        Z  = '0;
        A0 = fl(H, 0, 24'hA0);  A2 = fl(H, 0, 24'hA2);
        B0 = fl(H, 3, 24'hB0);  B1 = fl(B, 0, 24'hB1);
        B2 = fl(B, 0, 24'hB2);  B3 = fl(T, 0, 24'hB3);
        C2 = fl(H, 0, 24'hC2);
        D0 = fl(H, 0, 24'hD0);  D1 = fl(H, 0, 24'hD1);  D2 = fl(H, 0, 24'hD2);
        E0 = fl(H, 0, 24'hE0);  E1 = fl(H, 0, 24'hE1);  E2 = fl(H, 0, 24'hE2);
        E3 = fl(H, 0, 24'hE3);  E4 = fl(H, 0, 24'hE4);
        F0 = fl(H, 1, 24'hF0);  F1 = fl(T, 0, 24'hF1);
        G2 = fl(H, 0, 24'h62);

        // valid      f0  f1  f2  rdy cr      exp_rdy v  vc  data err
        addv(3'b101, A0, Z,  A2, 1, 3'b000, 3'b100, 1, 2, A2, 0);
        addv(3'b001, A0, Z,  Z,  1, 3'b000, 3'b001, 1, 0, A0, 0);
        addv(3'b000, Z,  Z,  Z,  1, 3'b000, 3'b000, 0, 0, Z,  0);
        addv(3'b000, Z,  Z,  Z,  1, 3'b101, 3'b000, 0, 0, Z,  0);
        addv(3'b010, Z,  B0, Z,  1, 3'b010, 3'b010, 1, 1, B0, 0);
        addv(3'b110, Z,  B1, C2, 1, 3'b010, 3'b010, 1, 1, B1, 0);
        addv(3'b110, Z,  B2, C2, 1, 3'b010, 3'b010, 1, 1, B2, 0);
        addv(3'b110, Z,  B3, C2, 1, 3'b010, 3'b010, 1, 1, B3, 0);
        addv(3'b100, Z,  Z,  C2, 1, 3'b000, 3'b100, 1, 2, C2, 0);
        addv(3'b000, Z,  Z,  Z,  1, 3'b100, 3'b000, 0, 0, Z,  0);
        addv(3'b001, D0, Z,  Z,  1, 3'b000, 3'b001, 1, 0, D0, 0);
        addv(3'b001, D1, Z,  Z,  1, 3'b000, 3'b001, 1, 0, D1, 0);
        addv(3'b001, D2, Z,  Z,  1, 3'b000, 3'b000, 0, 0, Z,  0);
        addv(3'b001, D2, Z,  Z,  1, 3'b000, 3'b000, 0, 0, Z,  0);
        addv(3'b001, D2, Z,  Z,  1, 3'b001, 3'b000, 0, 0, Z,  0);
        addv(3'b001, D2, Z,  Z,  1, 3'b000, 3'b001, 1, 0, D2, 0);
        addv(3'b000, Z,  Z,  Z,  1, 3'b001, 3'b000, 0, 0, Z,  0);
        addv(3'b000, Z,  Z,  Z,  1, 3'b001, 3'b000, 0, 0, Z,  0);
        addv(3'b010, Z,  E0, Z,  1, 3'b000, 3'b010, 1, 1, E0, 0);
        for (int i = 0; i < 4; i++)
            addv(3'b010, Z, E1, Z, 0, 3'b000, 3'b000, 1, 1, E0, 0);
        addv(3'b010, Z,  E1, Z,  1, 3'b000, 3'b010, 1, 1, E1, 0);
        addv(3'b000, Z,  Z,  Z,  1, 3'b010, 3'b000, 0, 0, Z,  0);
        addv(3'b000, Z,  Z,  Z,  1, 3'b010, 3'b000, 0, 0, Z,  0);
        addv(3'b000, Z,  Z,  Z,  1, 3'b010, 3'b000, 0, 0, Z,  1);
        addv(3'b000, Z,  Z,  Z,  1, 3'b000, 3'b000, 0, 0, Z,  1);
        addv(3'b010, Z,  E2, Z,  1, 3'b000, 3'b010, 1, 1, E2, 1);
        addv(3'b010, Z,  E3, Z,  1, 3'b000, 3'b010, 1, 1, E3, 1);
        addv(3'b010, Z,  E4, Z,  1, 3'b000, 3'b000, 0, 0, Z,  1);
        addv(3'b000, Z,  Z,  Z,  1, 3'b010, 3'b000, 0, 0, Z,  1);
        addv(3'b010, Z,  F0, Z,  1, 3'b000, 3'b010, 1, 1, F0, 1);
        addv(3'b110, Z,  F1, G2, 1, 3'b000, 3'b000, 0, 0, Z,  1);
        addv(3'b110, Z,  F1, G2, 1, 3'b000, 3'b000, 0, 0, Z,  1);
        addv(3'b110, Z,  F1, G2, 1, 3'b010, 3'b000, 0, 0, Z,  1);
        addv(3'b110, Z,  F1, G2, 1, 3'b000, 3'b010, 1, 1, F1, 1);
        addv(3'b100, Z,  Z,  G2, 1, 3'b000, 3'b100, 1, 2, G2, 1);
        addv(3'b000, Z,  Z,  Z,  1, 3'b010, 3'b000, 0, 0, Z,  1);

        arst = 1'b1;
        drive(3'b111, A0, A0, A0, 1, 3'b000);
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", ready_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_fdata", fdata_o, 0);
        check("rst_vcid", vc_id_o, 0);
        check("rst_err", credit_err_o, 0);
        drive(3'b000, Z, Z, Z, 1, 3'b000);
        arst = 1'b0;

`ifndef VC_SCHED_RR_EN
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].f0, vecs[i].f1, vecs[i].f2, vecs[i].rdy, vecs[i].cr);
            #1;
            check($sformatf("v%0d_ready", i), ready_o, vecs[i].exp_rdy);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), valid_o, vecs[i].exp_v);
            if (vecs[i].exp_v) begin
                check($sformatf("v%0d_vcid", i), vc_id_o, vecs[i].exp_vc);
                check($sformatf("v%0d_fdata", i), fdata_o, vecs[i].exp_d);
            end
            check($sformatf("v%0d_err", i), credit_err_o, vecs[i].exp_err);
        end
`else
        // Five round-robin grants leave the pointer at 2.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(3'b111, A0, A0, A2, 1, 3'b111);
            #1;
            check($sformatf("rr%0d_ready", k), ready_o, 3'(1 << (k % 3)));
            @(posedge clk);
            #1;
            check($sformatf("rr%0d_vcid", k), vc_id_o, 2'(k % 3));
        end
`endif

        // Lock VC1 on a multi-flit head, then reset mid-packet.
        @(negedge clk);
        drive(3'b010, Z, fl(H, 5, 24'h55), Z, 1, 3'b000);
        #1;
        check("lk_ready", ready_o, 3'b010);
        @(posedge clk);
        #1;
        check("lk_valid", valid_o, 1);
        check("lk_vcid", vc_id_o, 1);
        @(negedge clk);
        drive(3'b111, fl(H, 0, 24'h11), fl(B, 0, 24'h56), fl(H, 0, 24'h22), 1, 3'b000);
        arst = 1'b1;
        #1;
        check("mr_valid", valid_o, 0);
        check("mr_ready", ready_o, 0);
        check("mr_err", credit_err_o, 0);
        #1;
        arst = 1'b0;
        #1;
`ifndef VC_SCHED_RR_EN
        check("post_rst_ready", ready_o, 3'b100);
        @(posedge clk);
        #1;
        check("post_rst_vcid", vc_id_o, 2);
        check("post_rst_fdata", fdata_o, fl(H, 0, 24'h22));
`else
        check("post_rst_ready", ready_o, 3'b001);
        @(posedge clk);
        #1;
        check("post_rst_vcid", vc_id_o, 0);
        check("post_rst_fdata", fdata_o, fl(H, 0, 24'h11));
`endif
        check("post_rst_valid", valid_o, 1);

        @(negedge clk);
        drive(3'b000, Z, Z, Z, 1, 3'b000);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
